// File: rtl/ad9361_spi_pkg.sv
// Shared types and constants for the AD9361 SPI slave model: FSM states,
// emulated register addresses and instruction word field positions.
package ad9361_spi_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_INSTR,
        ST_WDATA,
        ST_RDATA,
        ST_DONE
    } spi_state_e;

    localparam logic [9:0] ADDR_CAL_CTRL    = 10'h016;
    localparam logic [9:0] ADDR_PRODUCT_ID  = 10'h037;
    localparam logic [9:0] ADDR_BBPLL_STAT  = 10'h05E;
    localparam logic [9:0] ADDR_RX_CP_STAT  = 10'h244;
    localparam logic [9:0] ADDR_RX_VCO_STAT = 10'h247;
    localparam logic [9:0] ADDR_TX_CP_STAT  = 10'h284;
    localparam logic [9:0] ADDR_TX_VCO_STAT = 10'h287;

    localparam int INSTR_BITS     = 16;
    localparam int INSTR_W_BIT    = 15;
    localparam int INSTR_NB_MSB   = 14;
    localparam int INSTR_NB_LSB   = 12;
    localparam int INSTR_RSV_MSB  = 11;
    localparam int INSTR_RSV_LSB  = 10;
    localparam int INSTR_ADDR_MSB = 9;
    localparam int INSTR_ADDR_LSB = 0;

    // Status bits that read as set once the emulated PLLs report lock.
    function automatic logic [7:0] lock_status_mask(input logic [9:0] addr);
        case (addr)
            ADDR_BBPLL_STAT, ADDR_RX_CP_STAT, ADDR_TX_CP_STAT: return 8'h80;
            ADDR_RX_VCO_STAT, ADDR_TX_VCO_STAT:                return 8'h02;
            default:                                           return 8'h00;
        endcase
    endfunction

endpackage

// File: rtl/ad9361_spi_slave_model_sync.sv
// Two-flop synchronizers for CS/SCLK/MOSI plus edge detection on CS and SCLK.
module spi_in_sync (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic cs_i,
    input  logic sclk_i,
    input  logic mosi_i,
    output logic cs_o,
    output logic mosi_o,
    output logic cs_fall_o,
    output logic cs_rise_o,
    output logic sclk_rise_o,
    output logic sclk_fall_o
);

    logic [2:0] cs_q;
    logic [2:0] sclk_q;
    logic [1:0] mosi_q;

    // CS chain resets high so releasing reset with CS idle yields no edge.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cs_q   <= '1;
            sclk_q <= '0;
            mosi_q <= '0;
        end else begin
            cs_q   <= {cs_q[1:0], cs_i};
            sclk_q <= {sclk_q[1:0], sclk_i};
            mosi_q <= {mosi_q[0], mosi_i};
        end
    end

    assign cs_o        = cs_q[1];
    assign mosi_o      = mosi_q[1];
    assign cs_fall_o   = cs_q[2] & ~cs_q[1];
    assign cs_rise_o   = ~cs_q[2] & cs_q[1];
    assign sclk_rise_o = ~sclk_q[2] & sclk_q[1];
    assign sclk_fall_o = sclk_q[2] & ~sclk_q[1];

endmodule

// File: rtl/ad9361_spi_slave_model.sv
// AD9361 4-wire SPI slave responder with register file, product ID, lock and
// self-clearing calibration emulation. SPI_SLV_MISO_TRISTATE_EN: float MISO when idle.
module ad9361_spi_slave_model
    import ad9361_spi_pkg::*;
#(
    parameter int         ADDR_W     = 10,
    parameter logic [7:0] PRODUCT_ID = 8'h0A,
    parameter int         CAL_DELAY  = 2000,
    parameter int         LOCK_DELAY = 500
) (
    input  logic              sys_clk,
    input  logic              sys_nrst,
    input  logic              spi_cs,
    input  logic              spi_sclk,
    input  logic              spi_mosi,
    output logic              spi_miso,
    output logic              wr_strobe,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [7:0]        wr_data,
    output logic              xfer_err
);

    localparam int LOCK_W = $clog2(LOCK_DELAY + 1);
    localparam int CAL_W  = $clog2(CAL_DELAY + 1);
    localparam logic [ADDR_W-1:0] A_PID = ADDR_W'(ADDR_PRODUCT_ID);
    localparam logic [ADDR_W-1:0] A_CAL = ADDR_W'(ADDR_CAL_CTRL);

    spi_state_e        state_q, state_d;
    logic              cs_s, mosi_s, cs_fall, cs_rise, sclk_rise, sclk_fall;
    logic [3:0]        bit_cnt_q;
    logic [14:0]       shift_q;
    logic [15:0]       rx_word;
    logic [ADDR_W-1:0] addr_q;
    logic [2:0]        nb_left_q;
    logic [7:0]        tx_q;
    logic              miso_q;
    logic              wr_strobe_q, xfer_err_q;
    logic [ADDR_W-1:0] wr_addr_q;
    logic [7:0]        wr_data_q;
    logic [LOCK_W-1:0] lock_cnt_q;
    logic [CAL_W-1:0]  cal_cnt_q;
    logic              cal_active_q;
    logic [7:0]        mem_q [2**ADDR_W];
    logic              instr_done, byte_done, partial, wr_en, cal_set, cal_expire, lock_ok;
    logic              miso_drive, unused_rsvd;
    logic [7:0]        rd_byte;

    spi_in_sync u_sync (
        .clk_i       (sys_clk),
        .rst_ni      (sys_nrst),
        .cs_i        (spi_cs),
        .sclk_i      (spi_sclk),
        .mosi_i      (spi_mosi),
        .cs_o        (cs_s),
        .mosi_o      (mosi_s),
        .cs_fall_o   (cs_fall),
        .cs_rise_o   (cs_rise),
        .sclk_rise_o (sclk_rise),
        .sclk_fall_o (sclk_fall)
    );

    assign rx_word     = {shift_q, mosi_s};
    assign unused_rsvd = ^rx_word[INSTR_RSV_MSB:INSTR_RSV_LSB];
    assign instr_done  = (state_q == ST_INSTR) && sclk_rise && (bit_cnt_q == 4'(INSTR_BITS - 1));
    assign byte_done   = (state_q inside {ST_WDATA, ST_RDATA}) && sclk_rise && (bit_cnt_q == 4'd7);
    assign partial     = (state_q inside {ST_INSTR, ST_WDATA, ST_RDATA}) && (bit_cnt_q[2:0] != 3'd0);
    assign wr_en       = (state_q == ST_WDATA) && byte_done && !cs_rise && (addr_q != A_PID);
    assign cal_set     = wr_en && (addr_q == A_CAL) && (rx_word[7:0] != 8'h00);
    assign cal_expire  = cal_active_q && (cal_cnt_q == CAL_W'(CAL_DELAY - 1));
    assign lock_ok     = (lock_cnt_q == LOCK_W'(LOCK_DELAY));

    always_comb begin
        if (addr_q == A_PID) rd_byte = PRODUCT_ID;
        else rd_byte = mem_q[addr_q] | (lock_ok ? lock_status_mask(10'(addr_q)) : 8'h00);
    end

    always_ff @(posedge sys_clk or negedge sys_nrst) begin
        if (!sys_nrst) state_q <= ST_IDLE;
        else           state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (cs_fall) state_d = ST_INSTR;
            ST_INSTR: if (instr_done) state_d = rx_word[INSTR_W_BIT] ? ST_WDATA : ST_RDATA;
            ST_WDATA, ST_RDATA: if (byte_done && nb_left_q == 3'd0) state_d = ST_DONE;
            default:  state_d = state_q;
        endcase
        if (cs_rise) state_d = ST_IDLE;
    end

    always_comb begin
        miso_drive = (state_q == ST_RDATA) && !cs_s;
    end

`ifdef SPI_SLV_MISO_TRISTATE_EN
    assign spi_miso = miso_drive ? miso_q : 1'bz;
`else
    assign spi_miso = miso_drive ? miso_q : 1'b0;
`endif

    assign wr_strobe = wr_strobe_q;
    assign wr_addr   = wr_addr_q;
    assign wr_data   = wr_data_q;
    assign xfer_err  = xfer_err_q;

    always_ff @(posedge sys_clk or negedge sys_nrst) begin
        if (!sys_nrst) begin
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            addr_q      <= '0;
            nb_left_q   <= '0;
            tx_q        <= '0;
            miso_q      <= 1'b0;
            wr_strobe_q <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
            xfer_err_q  <= 1'b0;
            lock_cnt_q  <= '0;
        end else begin
            wr_strobe_q <= 1'b0;
            if (!lock_ok) lock_cnt_q <= lock_cnt_q + 1'b1;
            if (cs_rise) begin
                // A partially shifted byte is dropped; only the error flag remembers it.
                bit_cnt_q <= '0;
                miso_q    <= 1'b0;
                if (partial) xfer_err_q <= 1'b1;
            end else begin
                case (state_q)
                    ST_IDLE: if (cs_fall) bit_cnt_q <= '0;
                    ST_INSTR: if (sclk_rise) begin
                        shift_q   <= rx_word[14:0];
                        bit_cnt_q <= bit_cnt_q + 4'd1;
                        if (instr_done) begin
                            bit_cnt_q <= '0;
                            addr_q    <= ADDR_W'(rx_word[INSTR_ADDR_MSB:INSTR_ADDR_LSB]);
                            nb_left_q <= rx_word[INSTR_NB_MSB:INSTR_NB_LSB];
                        end
                    end
                    ST_WDATA, ST_RDATA: begin
                        if (sclk_rise) begin
                            shift_q   <= rx_word[14:0];
                            bit_cnt_q <= bit_cnt_q + 4'd1;
                            if (byte_done) begin
                                bit_cnt_q <= '0;
                                addr_q    <= addr_q - 1'b1;
                                nb_left_q <= nb_left_q - 3'd1;
                            end
                        end
                        // Falling edge at a byte boundary loads the next byte, otherwise shifts.
                        if (state_q == ST_RDATA && sclk_fall) begin
                            if (bit_cnt_q == 4'd0) {miso_q, tx_q} <= {rd_byte, 1'b0};
                            else                   {miso_q, tx_q} <= {tx_q, 1'b0};
                        end
                        if (wr_en) begin
                            wr_strobe_q <= 1'b1;
                            wr_addr_q   <= addr_q;
                            wr_data_q   <= rx_word[7:0];
                        end
                    end
                    default: miso_q <= 1'b0;
                endcase
            end
        end
    end

    // Register file and calibration timer; a new cal write beats a same-cycle expiry.
    always_ff @(posedge sys_clk or negedge sys_nrst) begin
        if (!sys_nrst) begin
            for (int i = 0; i < 2**ADDR_W; i++) mem_q[i] <= '0;
            cal_cnt_q    <= '0;
            cal_active_q <= 1'b0;
        end else begin
            if (wr_en && addr_q != A_CAL) mem_q[addr_q] <= rx_word[7:0];
            if (cal_set)         mem_q[A_CAL] <= mem_q[A_CAL] | rx_word[7:0];
            else if (cal_expire) mem_q[A_CAL] <= 8'h00;
            if (cal_set) begin
                cal_cnt_q    <= '0;
                cal_active_q <= 1'b1;
            end else if (cal_expire) begin
                cal_active_q <= 1'b0;
            end else if (cal_active_q) begin
                cal_cnt_q <= cal_cnt_q + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_ad9361_spi_slave_model.sv
// Randomized and directed bench for ad9361_spi_slave_model against a register-level reference model.
`timescale 1ns/1ps
module tb_ad9361_spi_slave_model;
    import ad9361_spi_pkg::*;

    localparam int LOCK_DELAY = 500;
    localparam int CAL_DELAY  = 2000;
    localparam int H          = 4;

    logic       sys_clk  = 1'b0;
    logic       sys_nrst = 1'b0;
    logic       spi_cs   = 1'b1;
    logic       spi_sclk = 1'b0;
    logic       spi_mosi = 1'b0;
    logic       spi_miso;
    logic       wr_strobe;
    logic [9:0] wr_addr;
    logic [7:0] wr_data;
    logic       xfer_err;

    ad9361_spi_slave_model #(
        .ADDR_W     (10),
        .PRODUCT_ID (8'h0A),
        .CAL_DELAY  (CAL_DELAY),
        .LOCK_DELAY (LOCK_DELAY)
    ) dut (
        .sys_clk   (sys_clk),
        .sys_nrst  (sys_nrst),
        .spi_cs    (spi_cs),
        .spi_sclk  (spi_sclk),
        .spi_mosi  (spi_mosi),
        .spi_miso  (spi_miso),
        .wr_strobe (wr_strobe),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .xfer_err  (xfer_err)
    );

    always #5 sys_clk = ~sys_clk;

    int cyc = 0;
    always @(posedge sys_clk) cyc <= cyc + 1;

    logic [17:0] strobe_q[$];
    always @(negedge sys_clk) if (wr_strobe === 1'b1) strobe_q.push_back({wr_addr, wr_data});

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Reference model: register contents plus timestamps for lock and calibration.
    logic [7:0] ref_mem [1024];
    int         rst_cyc;
    int         cal_deadline;
    logic       cal_running;
    logic       exp_err;

    task automatic ref_reset();
        for (int i = 0; i < 1024; i++) ref_mem[i] = 8'h00;
        rst_cyc      = cyc;
        cal_running  = 1'b0;
        cal_deadline = 0;
        exp_err      = 1'b0;
    endtask

    function automatic logic [7:0] ref_read(input logic [9:0] a, input int t);
        logic [7:0] v;
        if (a == 10'h037) return 8'h0A;
        v = ref_mem[a];
        if (a == 10'h016 && cal_running && t >= cal_deadline) v = 8'h00;
        if (t - rst_cyc >= LOCK_DELAY) begin
            if (a inside {10'h05E, 10'h244, 10'h284}) v = v | 8'h80;
            if (a inside {10'h247, 10'h287})          v = v | 8'h02;
        end
        return v;
    endfunction

    task automatic ref_cal_write(input logic [7:0] d, input int t);
        if (d == 8'h00) return;
        if (cal_running && t >= cal_deadline) ref_mem[10'h016] = 8'h00;
        ref_mem[10'h016] = ref_mem[10'h016] | d;
        cal_deadline = t + CAL_DELAY;
        cal_running  = 1'b1;
    endtask

    logic [7:0] tx_bytes [8];
    logic [7:0] rx_bytes [8];

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge sys_clk);
    endtask

    task automatic wait_until(input int t);
        while (cyc < t) @(negedge sys_clk);
    endtask

    // Mode-0 bit clocking: MOSI set while SCLK low, MISO sampled as SCLK rises.
    task automatic spi_bits(input logic [15:0] instr, input int nbits);
        int j, b;
        for (int i = 0; i < nbits; i++) begin
            j = (i - 16) / 8;
            b = 7 - ((i - 16) % 8);
            if (i < 16) spi_mosi = instr[15 - i];
            else        spi_mosi = tx_bytes[j][b];
            wait_cyc(H);
            spi_sclk = 1'b1;
            if (i >= 16) rx_bytes[j][b] = spi_miso;
            wait_cyc(H);
            spi_sclk = 1'b0;
        end
    endtask

    task automatic spi_xfer(input logic [15:0] instr, input int nbits);
        spi_cs = 1'b0;
        wait_cyc(H);
        spi_bits(instr, nbits);
        wait_cyc(H);
        spi_cs   = 1'b1;
        spi_mosi = 1'b0;
        wait_cyc(8);
    endtask

    task automatic do_write(input logic [9:0] addr, input int n);
        logic [17:0] exp_q[$];
        logic [9:0]  a;
        int          start;
        start = cyc;
        strobe_q.delete();
        spi_xfer({1'b1, 3'(n - 1), 2'b00, addr}, 16 + 8 * n);
        for (int k = 0; k < n; k++) begin
            a = addr - 10'(k);
            if (a == 10'h037) continue;
            exp_q.push_back({a, tx_bytes[k]});
            if (a == 10'h016) ref_cal_write(tx_bytes[k], start + (16 + 8 * (k + 1)) * 2 * H);
            else              ref_mem[a] = tx_bytes[k];
        end
        $display("write addr=%03h n=%0d strobes=%0d err=%0b", addr, n, strobe_q.size(), xfer_err);
        check_eq("wr_count", strobe_q.size(), exp_q.size());
        for (int j = 0; j < exp_q.size() && j < strobe_q.size(); j++)
            check_eq($sformatf("wr_strobe[%0d]", j), 32'(strobe_q[j]), 32'(exp_q[j]));
        check_eq("xfer_err", 32'(xfer_err), 32'(exp_err));
    endtask

    task automatic do_read(input logic [9:0] addr, input int n);
        logic [9:0] a;
        int         start;
        start = cyc;
        spi_xfer({1'b0, 3'(n - 1), 2'b00, addr}, 16 + 8 * n);
        $display("read  addr=%03h n=%0d first=%02h err=%0b", addr, n, rx_bytes[0], xfer_err);
        for (int k = 0; k < n; k++) begin
            a = addr - 10'(k);
            check_eq($sformatf("rd %03h", a), 32'(rx_bytes[k]),
                     32'(ref_read(a, start + H + (16 + 8 * k) * 2 * H)));
        end
        check_eq("xfer_err", 32'(xfer_err), 32'(exp_err));
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int n, base;
        ref_reset();
        wait_cyc(4);
        check_eq("rst_miso_in_reset", 32'(spi_miso), 32'h0);
        check_eq("rst_err_in_reset", 32'(xfer_err), 32'h0);
        sys_nrst = 1'b1;
        ref_reset();
        wait_cyc(2);
        check_eq("rst_strobe", 32'(wr_strobe), 32'h0);
        check_eq("rst_wr_addr", 32'(wr_addr), 32'h0);
        check_eq("rst_wr_data", 32'(wr_data), 32'h0);
        check_eq("rst_miso", 32'(spi_miso), 32'h0);

        // Status before lock, then product ID
        do_read(10'h05E, 1);
        do_read(10'h037, 1);

        // Product ID is read-only
        tx_bytes[0] = 8'hFF;
        do_write(10'h037, 1);
        do_read(10'h037, 1);

        // Burst write with descending addresses, read back
        tx_bytes[0] = 8'h11; tx_bytes[1] = 8'h22; tx_bytes[2] = 8'h33;
        do_write(10'h102, 3);
        do_read(10'h102, 3);

        // Lock status after LOCK_DELAY
        wait_until(rst_cyc + LOCK_DELAY + 100);
        do_read(10'h05E, 1);
        do_read(10'h247, 1);
        do_read(10'h284, 1);

        // Calibration self-clear
        tx_bytes[0] = 8'h03;
        do_write(10'h016, 1);
        do_read(10'h016, 1);
        wait_until(cal_deadline + 10);
        do_read(10'h016, 1);

        // Rewrite halfway through extends the clear time
        tx_bytes[0] = 8'h03;
        do_write(10'h016, 1);
        base = cal_deadline;
        wait_until(base - CAL_DELAY / 2);
        tx_bytes[0] = 8'h04;
        do_write(10'h016, 1);
        wait_until(base + 20);
        do_read(10'h016, 1);
        wait_until(cal_deadline + 10);
        do_read(10'h016, 1);

        // CS raised 12 bits into the data phase
        tx_bytes[0] = 8'hAA; tx_bytes[1] = 8'hBB;
        do_write(10'h1C0, 2);
        tx_bytes[0] = 8'h5C; tx_bytes[1] = 8'hC5;
        strobe_q.delete();
        spi_xfer({1'b1, 3'd1, 2'b00, 10'h1C0}, 16 + 12);
        ref_mem[10'h1C0] = 8'h5C;
        exp_err = 1'b1;
        $display("abort addr=1C0 bits=12 strobes=%0d err=%0b", strobe_q.size(), xfer_err);
        check_eq("abort_strobes", strobe_q.size(), 1);
        check_eq("abort_err", 32'(xfer_err), 32'h1);
        do_read(10'h1C0, 2);

        // Address wrap below 0x000
        tx_bytes[0] = 8'h5A;
        do_write(10'h000, 1);
        tx_bytes[0] = 8'hC3; tx_bytes[1] = 8'h3C;
        do_write(10'h000, 2);
        do_read(10'h000, 2);

        // Random traffic in regions without special registers
        for (int it = 0; it < 24; it++) begin
            n    = $urandom_range(1, 8);
            base = ($urandom_range(0, 1) != 0 ? 'h300 : 'h100) + $urandom_range(8, 255);
            if ($urandom_range(0, 1) != 0) begin
                for (int k = 0; k < n; k++) tx_bytes[k] = 8'($urandom);
                do_write(10'(base), n);
            end else begin
                do_read(10'(base), n);
            end
        end

        // Reset in the middle of a read
        spi_cs = 1'b0;
        wait_cyc(H);
        spi_bits(16'h0037, 16 + 5);
        sys_nrst = 1'b0;
        #1;
        $display("reset mid-read miso=%0b err=%0b", spi_miso, xfer_err);
        check_eq("midrst_miso", 32'(spi_miso), 32'h0);
        check_eq("midrst_state", 32'(dut.state_q), 32'(ST_IDLE));
        check_eq("midrst_err", 32'(xfer_err), 32'h0);
        spi_cs   = 1'b1;
        spi_mosi = 1'b0;
        wait_cyc(4);
        sys_nrst = 1'b1;
        ref_reset();
        wait_cyc(4);
        do_read(10'h102, 2);
        do_read(10'h05E, 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/ad9361_spi_slave_model.md
Name: ad9361_spi_slave_model

Overview:
- Synthesizable responder for the AD9361 4-wire SPI slave interface.
- Sits on the far end of ad9361_spi_ctrl in simulation benches and in FPGA loopback builds when no RF chip is fitted.
- Decodes the 16-bit instruction and 1–8 data bytes, and keeps a byte-wide register file.
- Returns the product ID and emulates self-clearing calibration bits and PLL lock/cal-done status, so the init sequence runs to completion.

Parameters:
- ADDR_W, 10: register address width (1024 x 8 register file).
- PRODUCT_ID, 8'h0A: value returned at address 0x037 (read-only).
- CAL_DELAY, 2000: sys_clk cycles before written calibration bits in 0x016 self-clear.
- LOCK_DELAY, 500: sys_clk cycles after reset before lock/cal-done status bits read as 1.

Ports:
- sys_clk  in  1  system clock; must be at least 4x SCLK.
- sys_nrst  in  1  asynchronous active-low reset.
- spi_cs  in  1  chip select, active low.
- spi_sclk  in  1  SPI clock, idle low.
- spi_mosi  in  1  serial data in, MSB first.
- spi_miso  out  1  serial data out.
- wr_strobe  out  1  one-cycle pulse per completed write byte.
- wr_addr  out  ADDR_W  address of the last written byte.
- wr_data  out  8  data of the last written byte.
- xfer_err  out  1  sticky flag: CS deasserted mid-byte; cleared by reset only.

Behaviour:
- Reset values: spi_miso=0, wr_strobe=0, wr_addr=0, wr_data=0, xfer_err=0, all registers 0x00, FSM=IDLE, timers cleared.
- Synchronization: cs, sclk and mosi each pass through a 2-FF synchronizer, then SCLK rising/falling edge detect.
- SPI timing: MOSI sampled on SCLK rising edge; MISO updated on SCLK falling edge, about 3 sys_clk after the pin edge.
- FSM IDLE -> INSTR on CS falling edge; bit counter cleared.
- INSTR: shift 16 bits. Decode: bit15 = W (1 = write), bits14:12 = NB (byte count = NB+1), bits9:0 = start address.
- INSTR -> WDATA or RDATA after the 16th rising edge.
- WDATA: after each 8th bit, write the byte at the current address.
  - Pulse wr_strobe and update wr_addr/wr_data in the same cycle.
  - Writes to 0x037 are ignored and produce no strobe.
- RDATA: load the byte at the current address into the shift register on the falling edge following the 16th instruction bit (or the previous byte's last bit), then shift MSB first.
- Address decrements after every byte, wrapping from 0x000 to 0x3FF.
- Byte count exhausted -> DONE: further SCLK ignored and MISO held 0 until CS rises.
- Any state -> IDLE on CS rising edge.
  - If bit count mod 8 != 0 and state is WDATA/RDATA/INSTR with at least 1 bit shifted, set xfer_err and discard the partial byte.
- Read value mapping:
  - 0x037 returns PRODUCT_ID.
  - 0x016 returns stored bits not yet self-cleared.
  - 0x05E bit7, 0x244 bit7, 0x284 bit7, 0x247 bit1 and 0x287 bit1 are ORed with lock_ok.
  - All other addresses return the stored value.
- lock_ok: a counter runs from reset and saturates; lock_ok=1 once it reaches LOCK_DELAY.
- Cal timer: a write of a nonzero byte to 0x016 restarts the timer. When it reaches CAL_DELAY, 0x016 clears to 0x00. A new write during the countdown ORs in the new bits and restarts the timer.
- Simultaneous timer expiry and SPI write to 0x016 in the same cycle: the write wins, timer restarts.
- Reset mid-transfer: immediate return to IDLE with all state at reset values.

Optional Feature:
- SPI_SLV_MISO_TRISTATE_EN defined: spi_miso is 1'bz whenever CS is high or the FSM is not in RDATA, for shared-bus benches.
- Undefined: spi_miso drives 0 in those conditions.

Decomposition:
- Package ad9361_spi_pkg:
  - FSM state enum (IDLE, INSTR, WDATA, RDATA, DONE).
  - Address constants: ADDR_PRODUCT_ID=0x037, ADDR_CAL_CTRL=0x016, ADDR_BBPLL_STAT=0x05E, ADDR_RX_CP_STAT=0x244, ADDR_TX_CP_STAT=0x284, ADDR_RX_VCO_STAT=0x247, ADDR_TX_VCO_STAT=0x287.
  - Instruction field bit positions.
- One sub-module, spi_in_sync: 3-signal 2-FF synchronizer plus SCLK edge detector.

Test Plan:
- Read 1 byte at 0x037 (instr 0x0037) -> MISO returns 0x0A; xfer_err=0.
- Write 3 bytes at 0x102 (instr 0xA102, data 0x11,0x22,0x33) -> three wr_strobe pulses at 0x102/0x101/0x100; a 3-byte read (0x2102) returns 0x11,0x22,0x33.
- Read 0x05E at cycle < LOCK_DELAY -> bit7=0; the same read after LOCK_DELAY -> bit7=1.
- Write 0x016=0x03 -> reads 0x03 before CAL_DELAY and 0x00 after CAL_DELAY+10 cycles; a rewrite at CAL_DELAY/2 extends the clear time.
- CS raised after 12 bits of the data phase -> xfer_err=1, target register unchanged; the next full transfer still succeeds.
- Single-byte write at 0x000 then 2-byte write starting at 0x000 -> second byte lands at 0x3FF (wrap); reset asserted mid-read -> spi_miso=0, FSM=IDLE.
